// File: rtl/p09_pkg.sv
// Shared p09 painter constants: BBGGRR colour field width and palette entries.
package p09_pkg;

    localparam int COLOR_W = 6;

    localparam logic [COLOR_W-1:0] P09_COLOR_BLACK = 6'b000000;
    localparam logic [COLOR_W-1:0] P09_COLOR_WHITE = 6'b111111;
    localparam logic [COLOR_W-1:0] P09_COLOR_RED   = 6'b000011;

endpackage

// File: rtl/p09_flash_timer.sv
// Per-side flash countdown: load restarts at FLASH_FRAMES, tick counts down to zero.
module p09_flash_timer #(
    parameter logic [3:0] FLASH_FRAMES = 4'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic active
);

    logic [3:0] count_r;

    // Load has priority so a hit coinciding with a frame tick is a clean restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= FLASH_FRAMES;
        end else if (tick && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign active = (count_r != 4'd0);

endmodule

// File: rtl/p09_border_fx.sv
// Playfield border painter: side decode, per-side hit flash and attract-mode rainbow.
module p09_border_fx
    import p09_pkg::*;
#(
    parameter int                  BORDER_WIDTH = 8,
    parameter logic [2:0]          SIDE_MASK    = 3'b111,
    parameter logic [9:0]          BORDER_RIGHT = 10'd632,
    parameter logic [COLOR_W-1:0]  BASE_COLOR   = P09_COLOR_WHITE,
    parameter logic [COLOR_W-1:0]  FLASH_COLOR  = P09_COLOR_RED,
    parameter logic [3:0]          FLASH_FRAMES = 4'd8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         hpos,
    input  logic [8:0]         vpos,
    input  logic               frame_tick,
    input  logic [2:0]         hit,
    input  logic               attract,
    output logic               in_border,
    output logic [COLOR_W-1:0] color
);

    localparam int B = $clog2(BORDER_WIDTH);
    localparam logic [9:0] RIGHT_TILE = BORDER_RIGHT >> B;

    logic [2:0]         side_s;
    logic [2:0]         active_s;
    logic               in_border_s;
    logic               flash_s;
    logic [COLOR_W-1:0] color_s;
    logic [COLOR_W-1:0] hue_r;

    // One countdown per side; hits on masked-off sides never load.
    for (genvar i = 0; i < 3; i++) begin : g_side
        p09_flash_timer #(
            .FLASH_FRAMES(FLASH_FRAMES)
        ) u_timer (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (hit[i] & SIDE_MASK[i]),
            .tick  (frame_tick),
            .active(active_s[i])
        );
    end

    // Side membership and colour selection for the current pixel.
    always_comb begin
        side_s[0]   = ((hpos >> B) == 10'd0) & SIDE_MASK[0];
        side_s[1]   = ((hpos >> B) == RIGHT_TILE) & SIDE_MASK[1];
        side_s[2]   = ((vpos >> B) == 9'd0) & SIDE_MASK[2];
        in_border_s = |side_s;
        flash_s     = |(side_s & active_s);
        if (!in_border_s) begin
            color_s = P09_COLOR_BLACK;
        end else if (attract) begin
            color_s = hue_r;
        end else if (flash_s) begin
            color_s = FLASH_COLOR;
        end else begin
            color_s = BASE_COLOR;
        end
    end

    // Rainbow hue advances once per frame only in attract mode, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue_r <= P09_COLOR_BLACK;
        end else if (attract && frame_tick) begin
            hue_r <= hue_r + 6'd1;
        end else begin
            hue_r <= hue_r;
        end
    end

    // Output registers give exactly one cycle of latency from hpos/vpos.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_border <= 1'b0;
            color     <= P09_COLOR_BLACK;
        end else begin
            in_border <= in_border_s;
            color     <= color_s;
        end
    end

endmodule

// File: doc/p09_border_fx.md
P09_BORDER_FX -- requirements
Module: p09_border_fx

Interface
REQ-001 Parameter BORDER_WIDTH, default 8: border thickness in pixels; SHALL be a power of two, 1..64.
REQ-002 Parameter SIDE_MASK, default 3'b111: enable bits {top, right, left}.
REQ-003 Parameter BORDER_RIGHT, default 10'd632: hpos of the first pixel of the right border; SHALL be a multiple of BORDER_WIDTH.
REQ-004 Parameter BASE_COLOR, default 6'b111111: BBGGRR idle border color.
REQ-005 Parameter FLASH_COLOR, default 6'b000011: BBGGRR color shown while a side flashes.
REQ-006 Parameter FLASH_FRAMES, default 4'd8: flash duration in frames, 1..15.
REQ-007 clk  input  1  pixel clock; the only clock.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 hpos  input  10  current pixel column.
REQ-010 vpos  input  9  current pixel row.
REQ-011 frame_tick  input  1  single-cycle pulse, once per frame, during vertical blanking.
REQ-012 hit  input  3  single-cycle ball-contact pulses {top, right, left}.
REQ-013 attract  input  1  level; when high, selects rainbow mode.
REQ-014 in_border  output  1  registered: the current pixel is border.
REQ-015 color  output  6  registered BBGGRR border color; meaningful only when in_border=1.

Function
REQ-016 Side membership: left when hpos[9:B]==0; right when hpos[9:B]==BORDER_RIGHT[9:B]; top when vpos[8:B]==0; B=log2(BORDER_WIDTH); each side is gated by its SIDE_MASK bit.
REQ-017 in_border and color SHALL reflect the hpos/vpos sampled on the previous rising clk edge (exactly 1-cycle latency).
REQ-018 Each side has a 4-bit flash counter; a hit pulse on an enabled side loads FLASH_FRAMES on the next edge.
REQ-019 Each nonzero counter decrements by 1 on each frame_tick and saturates at 0.
REQ-020 A hit and a frame_tick on the same cycle for one side: reload wins, with no decrement that cycle.
REQ-021 A hit while that side is already flashing restarts the count at FLASH_FRAMES.
REQ-022 Hits on disabled sides are ignored; their counters stay 0.
REQ-023 Normal mode colour: FLASH_COLOR if any side covering the pixel has a nonzero counter, else BASE_COLOR; corner pixels flash if either covering side flashes.
REQ-024 Rainbow mode (attract=1): a 6-bit hue counter increments on each frame_tick and wraps 63->0; color = hue counter for every border pixel; flash is suppressed in the output but counters keep running.
REQ-025 The hue counter holds its value while attract=0.
REQ-026 When the pixel is not border, color SHALL output 0.

Reset
REQ-027 While rst_n=0: in_border=0, color=0, all flash counters=0, hue counter=0, applied asynchronously.
REQ-028 Reset release SHALL be synchronous to clk; the first valid output follows the first edge after release.
REQ-029 Reset during a flash SHALL abort it; no flash resumes after release.

Structure
REQ-030 The BBGGRR colour constants and the colour field width (6) belong in the shared p09 constants header, shared with the other painters.
REQ-031 The per-side counter SHALL be one sub-module, p09_flash_timer (load, tick, active output), instantiated three times.
REQ-032 Side decode is combinational; only the counters, the hue counter and the two outputs are registered.

Verification
REQ-033 Reset: rst_n=0 mid-frame -> in_border=0, color=0 immediately, without waiting for a clk edge.
REQ-034 Latency: hpos=0, vpos=100 -> in_border=1, color=6'b111111 one cycle later; hpos=320, vpos=100 -> in_border=0, color=0.
REQ-035 Flash: hit=3'b001, then 8 frame_ticks -> left pixels show 6'b000011 for exactly 8 frames, then 6'b111111; right side stays 6'b111111 throughout.
REQ-036 Collision: hit[2] and frame_tick asserted on the same cycle while the top counter is 3 -> counter becomes 8.
REQ-037 Corner: top flashing, left idle, pixel (0,0) -> color=6'b000011.
REQ-038 Rainbow: attract=1, 70 frame_ticks from reset -> color=6 (wrap verified); SIDE_MASK=3'b011 -> vpos=0, hpos=320 gives in_border=0.
